wake_detect: RTL and testbench



---
 rtl/wake_detect_if.sv | 18 +
 rtl/wake_detect.sv | 140 ++++++++++++++
 tb/tb_wake_detect.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/wake_detect_if.sv
// Argmax result stream into the wake stage.
// Signals:
//   data  - one-hot class vector from argmax (NUM_CLASSES bits)
//   valid - beat valid
//   last  - final beat of a stream segment
//   ready - beat accepted when valid & ready
// Modports: master drives the beat; slave (the wake stage) drives ready.
interface wake_detect_if #(
  parameter int unsigned NUM_CLASSES = 2
) ();
  logic [NUM_CLASSES-1:0] data;
  logic                   valid;
  logic                   last;
  logic                   ready;

  modport master (output data, output valid, output last, input ready);
  modport slave  (input data, input valid, input last, output ready);
endinterface

// File: rtl/wake_detect.sv
// Sliding-window wake detector: raises wake_o when WAKE_CLASS wins at least
// THRESHOLD of the last WINDOW_LEN argmax results, holds it HOLD_CYCLES, then
// observes a COOLDOWN_CYCLES refractory period.
// Ports:
//   clk_i       - clock
//   rst_n_i     - synchronous active-low reset
//   s_if        - argmax beat stream (slave side: data/valid/last in, ready out)
//   enable_i    - detection enable (static config)
//   wake_o      - registered wake pin
//   hit_count_o - registered popcount of the vote window (status only)
module wake_detect #(
  parameter int unsigned NUM_CLASSES     = 2,
  parameter int unsigned WAKE_CLASS      = 1,
  parameter int unsigned WINDOW_LEN      = 4,
  parameter int unsigned THRESHOLD       = 3,
  parameter int unsigned HOLD_CYCLES     = 16,
  parameter int unsigned COOLDOWN_CYCLES = 64
) (
  input  logic                              clk_i,
  input  logic                              rst_n_i,
  wake_detect_if.slave                      s_if,
  input  logic                              enable_i,
  output logic                              wake_o,
  output logic [$clog2(WINDOW_LEN+1)-1:0]   hit_count_o
);

  localparam int unsigned HC_W    = $clog2(WINDOW_LEN + 1);
  localparam int unsigned CNT_MAX = (HOLD_CYCLES > COOLDOWN_CYCLES) ? HOLD_CYCLES : COOLDOWN_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [NUM_CLASSES-1:0] HIT_PAT   = NUM_CLASSES'(1) << WAKE_CLASS;
  localparam logic [CNT_W-1:0]       HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0]       COOL_LOAD =
    CNT_W'((COOLDOWN_CYCLES == 0) ? 0 : COOLDOWN_CYCLES - 1);
  localparam logic [HC_W-1:0]        THR       = HC_W'(THRESHOLD);

  // Reject illegal configurations at elaboration.
  if (NUM_CLASSES < 1 || WAKE_CLASS >= NUM_CLASSES || WINDOW_LEN < 1 ||
      THRESHOLD < 1 || THRESHOLD > WINDOW_LEN || HOLD_CYCLES < 1) begin : g_bad_params
    $error("wake_detect: illegal parameter combination");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAKE = 2'd1,
    S_COOL = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [WINDOW_LEN-1:0]   win_q, win_d;
  logic [HC_W-1:0]         hc_q, hc_d;
  logic                    wake_q, wake_d;
  logic                    ready_q;

  logic                    accept;
  logic                    hit;
  logic [WINDOW_LEN-1:0]   win_shift;
  logic                    trig;

  function automatic logic [HC_W-1:0] popcount(input logic [WINDOW_LEN-1:0] v);
    logic [HC_W-1:0] c;
    c = '0;
    for (int i = 0; i < WINDOW_LEN; i++) c = c + HC_W'(v[i]);
    return c;
  endfunction

  // Beat qualification; zero-hot and multi-hot beats are simply non-hits.
  assign accept    = s_if.valid & ready_q;
  assign hit       = accept & (s_if.data == HIT_PAT);
  // Truncating {win,hit} keeps the newest WINDOW_LEN results (also valid for WINDOW_LEN==1).
  assign win_shift = WINDOW_LEN'({win_q, hit});
  assign trig      = accept & enable_i & (popcount(win_shift) >= THR);

  // State and datapath registers.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      win_q   <= '0;
      hc_q    <= '0;
      wake_q  <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      win_q   <= win_d;
      hc_q    <= hc_d;
      wake_q  <= wake_d;
      ready_q <= 1'b1;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (trig) state_d = S_WAKE;
      S_WAKE: if (cnt_q == '0) state_d = (COOLDOWN_CYCLES == 0) ? S_IDLE : S_COOL;
      S_COOL: if (cnt_q == '0) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Counter, window and registered-output next values.
  always_comb begin
    cnt_d = cnt_q;
    win_d = win_q;
    case (state_q)
      S_IDLE: begin
        if (!enable_i) begin
          win_d = '0;
        end else if (accept) begin
          // Trigger consumes the window; last closes the segment either way.
          win_d = (trig || s_if.last) ? '0 : win_shift;
        end
        if (trig) cnt_d = HOLD_LOAD;
      end
      S_WAKE: begin
        win_d = '0;
        cnt_d = (cnt_q == '0) ? COOL_LOAD : cnt_q - CNT_W'(1);
      end
      S_COOL: begin
        win_d = '0;
        if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
      end
      default: begin
        win_d = '0;
        cnt_d = '0;
      end
    endcase
    hc_d   = popcount(win_d);
    wake_d = (state_d == S_WAKE);
  end

  assign s_if.ready  = ready_q;
  assign wake_o      = wake_q;
  assign hit_count_o = hc_q;

endmodule

// File: tb/tb_wake_detect.sv
// Bench for wake_detect with default parameters: directed scenarios plus a
// randomized stretch, all compared against a queue/timer reference model.
module tb_wake_detect;

  localparam int unsigned NC   = 2;
  localparam int unsigned WC   = 1;
  localparam int unsigned WIN  = 4;
  localparam int unsigned THR  = 3;
  localparam int unsigned HOLD = 16;
  localparam int unsigned COOL = 64;

  localparam logic [1:0] H  = 2'b10;
  localparam logic [1:0] N  = 2'b01;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable;
  logic       wake;
  logic [2:0] hc;

  always #5 clk = ~clk;

  wake_detect_if #(.NUM_CLASSES(NC)) bus ();

  wake_detect #(
    .NUM_CLASSES(NC), .WAKE_CLASS(WC), .WINDOW_LEN(WIN),
    .THRESHOLD(THR), .HOLD_CYCLES(HOLD), .COOLDOWN_CYCLES(COOL)
  ) dut (
    .clk_i(clk),
    .rst_n_i(rst_n),
    .s_if(bus),
    .enable_i(enable),
    .wake_o(wake),
    .hit_count_o(hc)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Reference model: window as a queue of recent hit flags, wake/cooldown as
  // remaining-cycle timers.
  bit m_ready     = 1'b0;
  int m_wake_left = 0;
  int m_cool_left = 0;
  bit m_win[$];

  function automatic int m_sum();
    int s = 0;
    foreach (m_win[i]) s += int'(m_win[i]);
    return s;
  endfunction

  task automatic model_step(input bit r, input bit v, input logic [1:0] d,
                            input bit l, input bit en);
    bit acc, h;
    if (!r) begin
      m_win.delete();
      m_wake_left = 0;
      m_cool_left = 0;
      m_ready     = 1'b0;
      return;
    end
    acc     = v && m_ready;
    h       = acc && ($countones(d) == 1) && d[WC];
    m_ready = 1'b1;
    if (m_wake_left > 0) begin
      m_wake_left--;
      if (m_wake_left == 0) m_cool_left = COOL;
    end else if (m_cool_left > 0) begin
      m_cool_left--;
    end else if (!en) begin
      m_win.delete();
    end else if (acc) begin
      m_win.push_back(h);
      if (m_win.size() > WIN) void'(m_win.pop_front());
      if (m_sum() >= THR) begin
        m_win.delete();
        m_wake_left = HOLD;
      end else if (l) begin
        m_win.delete();
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s @cycle %0d: observed %0d expected %0d", tag, cyc, obs, exp);
    end
  endtask

  // One clock: drive beat, step model on the edge, compare #1 later.
  task automatic tick(input bit r, input bit v, input logic [1:0] d, input bit l);
    rst_n     = r;
    bus.valid = v;
    bus.data  = d;
    bus.last  = l;
    @(posedge clk);
    model_step(r, v, d, l, enable);
    cyc++;
    #1;
    chk("wake_model", 32'(wake), 32'(m_wake_left > 0));
    chk("hit_count_model", 32'(hc), 32'(m_sum()));
    chk("ready_model", 32'(bus.ready), 32'(m_ready));
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200 && (m_wake_left > 0 || m_cool_left > 0); i++) tick(1, 0, 2'b00, 0);
    chk("idle_wake_low", 32'(wake), 32'd0);
  endtask

  initial begin
    int n;
    rst_n     = 1'b0;
    enable    = 1'b1;
    bus.valid = 1'b0;
    bus.data  = '0;
    bus.last  = 1'b0;

    // Reset state
    tick(0, 0, 2'b00, 0);
    tick(0, 1, H, 0);
    chk("rst_ready", 32'(bus.ready), 32'd0);
    chk("rst_wake", 32'(wake), 32'd0);
    chk("rst_hc", 32'(hc), 32'd0);
    tick(1, 0, 2'b00, 0);
    chk("ready_after_rst", 32'(bus.ready), 32'd1);

    // Scenario 1: 01,10,10,10 -> wake on 4th accept, 16-cycle hold
    tick(1, 1, N, 0); chk("s1_hc0", 32'(hc), 32'd0);
    tick(1, 1, H, 0); chk("s1_hc1", 32'(hc), 32'd1);
    tick(1, 1, H, 0); chk("s1_hc2", 32'(hc), 32'd2); chk("s1_nowake", 32'(wake), 32'd0);
    tick(1, 1, H, 0); chk("s1_wake", 32'(wake), 32'd1); chk("s1_hc_clr", 32'(hc), 32'd0);
    n = 1;
    for (int i = 0; i < 100 && wake === 1'b1; i++) begin
      tick(1, 0, 2'b00, 0);
      if (wake === 1'b1) n++;
    end
    chk("s1_hold_len", 32'(n), 32'(HOLD));

    // Scenario 4: beats during cooldown discarded; afterwards two hits, then third wakes
    for (int i = 0; i < 8; i++) begin
      tick(1, 1, H, 0);
      chk("cool_ready", 32'(bus.ready), 32'd1);
      chk("cool_nowake", 32'(wake), 32'd0);
    end
    for (int i = 0; i < COOL - 8; i++) tick(1, 0, 2'b00, 0);
    chk("cool_end_hc", 32'(hc), 32'd0);
    tick(1, 1, H, 0); chk("post_cool_hc1", 32'(hc), 32'd1);
    tick(1, 1, H, 0); chk("post_cool_hc2", 32'(hc), 32'd2); chk("post_cool_nowake", 32'(wake), 32'd0);
    tick(1, 1, H, 0); chk("post_cool_wake", 32'(wake), 32'd1);
    wait_idle();

    // Scenario 2: sliding window 10,01,10,01,10 stays at 2; extra 10 reaches 3
    tick(1, 1, H, 0); chk("s2_hc_a", 32'(hc), 32'd1);
    tick(1, 1, N, 0); chk("s2_hc_b", 32'(hc), 32'd1);
    tick(1, 1, H, 0); chk("s2_hc_c", 32'(hc), 32'd2);
    tick(1, 1, N, 0); chk("s2_hc_d", 32'(hc), 32'd2);
    tick(1, 1, H, 0); chk("s2_hc_e", 32'(hc), 32'd2); chk("s2_nowake", 32'(wake), 32'd0);
    tick(1, 1, H, 0); chk("s2_wake", 32'(wake), 32'd1);
    wait_idle();

    // Scenario 3: last_i closes the segment
    tick(1, 1, H, 0);
    tick(1, 1, H, 1);
    tick(1, 1, H, 0); chk("s3_hc", 32'(hc), 32'd1); chk("s3_nowake", 32'(wake), 32'd0);

    // Scenario 5: invalid one-hot never counts; disabled detection never wakes
    tick(1, 1, 2'b00, 1);
    for (int i = 0; i < 10; i++) begin
      tick(1, 1, 2'b11, 0);
      tick(1, 1, 2'b00, 0);
      chk("inv_hc", 32'(hc), 32'd0);
    end
    enable = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick(1, 1, H, 0);
      chk("dis_hc", 32'(hc), 32'd0);
      chk("dis_nowake", 32'(wake), 32'd0);
    end
    enable = 1'b1;

    // Scenario 6: reset during hold cycle 5 aborts, then normal operation resumes
    tick(1, 1, H, 0);
    tick(1, 1, H, 0);
    tick(1, 1, H, 0); chk("s6_wake", 32'(wake), 32'd1);
    for (int i = 0; i < 4; i++) tick(1, 0, 2'b00, 0);
    chk("s6_still_wake", 32'(wake), 32'd1);
    tick(0, 1, H, 0);
    chk("s6_rst_wake", 32'(wake), 32'd0);
    chk("s6_rst_ready", 32'(bus.ready), 32'd0);
    chk("s6_rst_hc", 32'(hc), 32'd0);
    tick(1, 0, 2'b00, 0); chk("s6_ready", 32'(bus.ready), 32'd1);
    tick(1, 1, H, 0);
    tick(1, 1, H, 0);
    tick(1, 1, H, 0); chk("s6_rewake", 32'(wake), 32'd1);
    wait_idle();

    // Randomized traffic against the model
    for (int k = 0; k < 700; k++) begin
      bit         r, v, l;
      logic [1:0] d;
      if (k == 300) enable = 1'b0;
      if (k == 360) enable = 1'b1;
      r = ($urandom_range(0, 99) != 0);
      v = ($urandom_range(0, 3) != 0);
      d = ($urandom_range(0, 1) == 1) ? H : 2'($urandom_range(0, 3));
      l = ($urandom_range(0, 7) == 0);
      tick(r, v, d, l);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
